seg_scan_controller: RTL

Time-multiplexing scheduler for the four-digit seven-segment display. Shares the single 5-bit-code segment decoder among four digit positions. Rotates an active-low anode select at a fixed scan rate and inserts an all-off guard interval at each digit change to suppress ghosting. Takes new display frames through a double-buffered load port and, optionally, blinks selected digits; its `code_out` drives the segment decoder's 5-bit code input.

---
 rtl/seg_scan_controller.sv | 117 +++++++++++
 1 files changed

// File: rtl/seg_scan_controller.sv
// seg_scan_controller: four-digit seven-segment scan scheduler.
// Rotates an active-low anode select, blanks all anodes for GUARD cycles at
// each digit change, and double-buffers incoming frames. A new frame is
// applied only at a frame boundary. Optional digit blinking is built when
// SEG_SCAN_BLINK_EN is defined.
module seg_scan_controller #(
  parameter int SCAN_DIV     = 50000,
  parameter int GUARD        = 16,
  parameter int BLINK_FRAMES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_load,
  input  logic [19:0] frame_in,
  input  logic [3:0]  blink_mask,
  output logic [4:0]  code_out,
  output logic [3:0]  an,
  output logic [1:0]  digit_sel,
  output logic        frame_busy
);

  localparam int         CW    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [4:0] BLANK = 5'd18;

  logic [CW-1:0]   cnt, cnt_nxt;
  logic            tick, boundary;
  logic [1:0]      ds_nxt;
  logic [3:0]      an_nxt;
  logic [3:0][4:0] act, pend, act_nxt;
  logic [4:0]      raw_code, code_nxt;
  logic            apply;

  // Slot timing: the prescaler wraps each tick and advances the digit.
  always_comb begin
    tick     = (cnt == CW'(SCAN_DIV - 1));
    boundary = tick && (digit_sel == 2'd3);
    cnt_nxt  = tick ? '0 : cnt + CW'(1);
    ds_nxt   = tick ? digit_sel + 2'd1 : digit_sel;
    an_nxt   = (cnt_nxt < CW'(GUARD)) ? 4'b1111 : ~(4'b0001 << ds_nxt);
  end

  // Pending frame is promoted at a boundary so digit 0 of the new frame
  // already sees it when code_out is reloaded on that same edge.
  always_comb begin
    apply    = boundary && frame_busy;
    act_nxt  = apply ? pend : act;
    raw_code = act_nxt[ds_nxt];
  end

`ifdef SEG_SCAN_BLINK_EN
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [FW-1:0] fcnt;
  logic          hidden, hidden_nxt, fwrap;

  // Blink phase flips after BLINK_FRAMES boundaries; the next phase is used
  // so digit 0 of a new frame already reflects the flip.
  always_comb begin
    fwrap      = boundary && (fcnt == FW'(BLINK_FRAMES - 1));
    hidden_nxt = fwrap ? ~hidden : hidden;
    code_nxt   = (hidden_nxt && blink_mask[ds_nxt]) ? BLANK : raw_code;
  end

  // Frame counter and blink phase register.
  always_ff @(posedge clk) begin
    if (rst) begin
      fcnt   <= '0;
      hidden <= 1'b0;
    end else begin
      if (boundary) fcnt <= fwrap ? '0 : fcnt + FW'(1);
      hidden <= hidden_nxt;
    end
  end
`else
  logic blink_unused;
  assign blink_unused = ^blink_mask;

  // Without blinking the decoder always sees the active register.
  always_comb begin
    code_nxt = raw_code;
  end
`endif

  // Scan state and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      digit_sel <= 2'd0;
      an        <= 4'b1111;
      code_out  <= BLANK;
    end else begin
      cnt       <= cnt_nxt;
      digit_sel <= ds_nxt;
      an        <= an_nxt;
      if (tick) code_out <= code_nxt;
    end
  end

  // Double buffer: a load always lands in pending; a load coinciding with
  // a boundary keeps busy set so it is applied at the following boundary.
  always_ff @(posedge clk) begin
    if (rst) begin
      act        <= {4{BLANK}};
      pend       <= {4{BLANK}};
      frame_busy <= 1'b0;
    end else begin
      act <= act_nxt;
      if (frame_load) begin
        pend       <= frame_in;
        frame_busy <= 1'b1;
      end else if (apply) begin
        frame_busy <= 1'b0;
      end
    end
  end

endmodule
